// File: rtl/pipe_pkg.sv
// Shared pipeline constants: data/address widths and MEM/WB bundle field offsets.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package pipe_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    // MEM/WB bundle layout, LSB first: alu_out, dm_out, MemtoReg, RegWrite
    localparam int MWB_ALU_LSB = 0;
    localparam int MWB_DM_LSB  = DW;
    localparam int MWB_M2R_BIT = 2 * DW;
    localparam int MWB_RW_BIT  = 2 * DW + 1;
    localparam int MWB_W       = 2 * DW + 2;

endpackage

// File: rtl/gpr_array.sv
// Raw GPR storage: one write port, three asynchronous read ports, asynchronous clear.
// Latency: write visible after 1 clock; reads combinational.
// Backpressure: none; a write is accepted on every cycle that we is high.
module gpr_array #(
    parameter int DW = pipe_pkg::DW,
    parameter int AW = pipe_pkg::AW
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    input  logic [AW-1:0] raddr_c,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic [DW-1:0] rdata_c
);

    localparam int NREGS = 1 << AW;

    logic [DW-1:0] mem [NREGS];

    // Clear every entry on reset, otherwise commit the single write port
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
    assign rdata_c = mem[raddr_c];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: unpacks MEM/WB, selects load/ALU value, commits to the GPR file with WB->ID bypass.
// Latency: commit 1 clock; ID reads, bypass and debug read are combinational.
// Backpressure: none; the writeback stage never stalls and consumes the bundle every cycle.
module wb_regfile #(
    parameter int DW    = pipe_pkg::DW,
    parameter int AW    = pipe_pkg::AW,
    parameter int CNT_W = 32
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic [pipe_pkg::MWB_W-1:0] mem_wb_in,
    input  logic [AW-1:0]              wb_rd,
    input  logic [AW-1:0]              ra1,
    input  logic [AW-1:0]              ra2,
    output logic [DW-1:0]              rd1,
    output logic [DW-1:0]              rd2,
    input  logic [AW-1:0]              dbg_addr,
    output logic [DW-1:0]              dbg_data,
    output logic                       wb_we,
    output logic [DW-1:0]              wb_data,
    output logic [CNT_W-1:0]           wr_count
);

    import pipe_pkg::*;

    logic [DW-1:0] alu_out;
    logic [DW-1:0] dm_out;
    logic          mem_to_reg;
    logic          reg_write;

    logic [DW-1:0] arr_rd1;
    logic [DW-1:0] arr_rd2;

    // Bundle unpack
    assign alu_out    = mem_wb_in[MWB_ALU_LSB +: DW];
    assign dm_out     = mem_wb_in[MWB_DM_LSB +: DW];
    assign mem_to_reg = mem_wb_in[MWB_M2R_BIT];
    assign reg_write  = mem_wb_in[MWB_RW_BIT];

    // r0 is hardwired: gating the enable here keeps the array entry at zero forever.
    // reg_write alone qualifies the write, so garbage data fields while it is low are harmless.
    assign wb_data = mem_to_reg ? dm_out : alu_out;
    assign wb_we   = reg_write && (wb_rd != '0);

    gpr_array #(
        .DW (DW),
        .AW (AW)
    ) u_gpr (
        .clock   (clock),
        .rst_n   (rst_n),
        .we      (wb_we),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (ra1),
        .raddr_b (ra2),
        .raddr_c (dbg_addr),
        .rdata_a (arr_rd1),
        .rdata_b (arr_rd2),
        .rdata_c (dbg_data)
    );

    // ID read ports: r0 forced to zero, then same-cycle bypass of the in-flight write, then the array
    always_comb begin
        rd1 = arr_rd1;
        rd2 = arr_rd2;
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (wb_we && (ra1 == wb_rd)) begin
            rd1 = wb_data;
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (wb_we && (ra2 == wb_rd)) begin
            rd2 = wb_data;
        end
    end

    // Retired-write counter, wraps naturally at 2**CNT_W
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (wb_we) begin
            wr_count <= wr_count + 1'b1;
        end
    end

endmodule
